// File: rtl/pipeline_hazard_unit.sv
// ============================================================================
// pipeline_hazard_unit: load-use stall, ALU forwarding and branch flush control
// for a five-stage LEGv8 pipeline, with saturating performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int ZERO_REG     = 31,
  parameter int BRANCH_STAGE = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  br_taken_i,
  input  logic                  clear_counters_i,
  output logic                  stall_o,
  output logic                  flush_if_id_o,
  output logic                  flush_id_ex_o,
  output logic                  flush_ex_mem_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic [CNT_W-1:0]      flush_count_o,
  output logic [CNT_W-1:0]      retire_count_o
);

  localparam logic [REG_ADDR_W-1:0] C_ZERO_RD = ZERO_REG[REG_ADDR_W-1:0];
  localparam logic                  C_KILL_EX_MEM = (BRANCH_STAGE == 3);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  sb_entry_t        ex_q, mem_q, wb_q;
  sb_entry_t        ex_d, mem_d;
  logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  state_t           state_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;

  logic flush_w, stall_w, advance_w;
  logic ex_hit_a_w, ex_hit_b_w, mem_hit_a_w, mem_hit_b_w;

  function automatic logic hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] rs,
                               input logic use_rs);
    return use_rs && e.valid && e.regwrite && (e.rd != C_ZERO_RD) && (e.rd == rs);
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt, input logic inc,
                                            input logic clr);
    if (clr)
      return '0;
    else if (inc && (cnt != '1))
      return cnt + CNT_W'(1);
    else
      return cnt;
  endfunction

  // Flush outputs are suppressed while reset is held.
  assign flush_w     = br_taken_i & rst_ni;

  assign ex_hit_a_w  = hit(ex_q,  id_rs1_i, id_use_rs1_i);
  assign ex_hit_b_w  = hit(ex_q,  id_rs2_i, id_use_rs2_i);
  assign mem_hit_a_w = hit(mem_q, id_rs1_i, id_use_rs1_i);
  assign mem_hit_b_w = hit(mem_q, id_rs2_i, id_use_rs2_i);

  assign stall_w   = id_valid_i && !flush_w && ex_q.memread && (ex_hit_a_w || ex_hit_b_w);
  assign advance_w = id_valid_i && !stall_w && !flush_w;

  always_comb begin
    ex_d          = '0;
    mem_d         = ex_q;
    fwd_a_d       = 2'b00;
    fwd_b_d       = 2'b00;
    if (advance_w) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
      // EX producer is one stage younger than MEM, so it takes precedence.
      fwd_a_d = ex_hit_a_w ? 2'b10 : (mem_hit_a_w ? 2'b01 : 2'b00);
      fwd_b_d = ex_hit_b_w ? 2'b10 : (mem_hit_b_w ? 2'b01 : 2'b00);
    end
    if (flush_w && C_KILL_EX_MEM)
      mem_d.valid = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      fwd_a_q      <= 2'b00;
      fwd_b_q      <= 2'b00;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= mem_q;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      stall_cnt_q  <= bump(stall_cnt_q,  stall_w,    clear_counters_i);
      flush_cnt_q  <= bump(flush_cnt_q,  flush_w,    clear_counters_i);
      retire_cnt_q <= bump(retire_cnt_q, wb_q.valid, clear_counters_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state_q <= ST_RUN;
    else if (flush_w)
      state_q <= ST_FLUSH;
    else if (stall_w)
      state_q <= ST_STALL;
    else
      state_q <= ST_RUN;
  end

  assign stall_o        = stall_w;
  assign flush_if_id_o  = flush_w;
  assign flush_id_ex_o  = flush_w;
  assign flush_ex_mem_o = flush_w & C_KILL_EX_MEM;
  assign fwd_a_o        = fwd_a_q;
  assign fwd_b_o        = fwd_b_q;
  assign state_o        = state_q;
  assign stall_count_o  = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
  assign retire_count_o = retire_cnt_q;

endmodule

`default_nettype wire
